// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framing constants, TX state type and CRC-32 step
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam int MIN_PAYLOAD_BYTES = 46;
  localparam int IFG_CYCLES        = 48;

  // Cycles spent in each state, one dibit per cycle.
  localparam int PREAMBLE_CYCLES = 32;
  localparam int HEADER_CYCLES   = 56;
  localparam int PAYLOAD_CYCLES  = MIN_PAYLOAD_BYTES * 4;
  localparam int FCS_CYCLES      = 16;

  // Reflected CRC-32 advanced by one dibit, d[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc32_step2(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - 2-bit-per-cycle reflected CRC-32 register
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_step2(crc, d);
    end
  end

endmodule

// File: rtl/transmit.sv
// rtl/transmit.sv - RMII transmit framer: one 32-bit word per padded Ethernet II frame
module transmit
  import eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        eth_refclk,
  input  logic        rstn,
  input  logic        axiiv,
  input  logic [31:0] axiid,
  output logic        axiir,
  output logic        eth_txen,
  output logic [1:0]  eth_txd
);

  localparam logic [111:0] HDR = {DEST_MAC, SRC_MAC, ETHERTYPE};

  tx_state_t   state, next_state;
  logic [7:0]  cnt, cnt_next;
  logic [31:0] word;
  logic [31:0] crc;
  logic        crc_init, crc_en, latch;
  logic        txen_d;
  logic [1:0]  txd_d;

  logic [7:0]  pre_byte, hdr_byte, pay_byte;
  logic [6:0]  hdr_base;
  logic [4:0]  pay_base;
  logic [31:0] fcs;

  // cnt[1:0] picks the dibit within a byte, the upper bits pick the byte.
  assign pre_byte = (cnt[4:2] == 3'd7) ? SFD_BYTE : PREAMBLE_BYTE;
  assign hdr_base = 7'd104 - {cnt[5:2], 3'b000};
  assign hdr_byte = HDR[hdr_base +: 8];
  assign pay_base = 5'd24 - {cnt[3:2], 3'b000};
  assign pay_byte = (cnt[7:2] < 6'd4) ? word[pay_base +: 8] : 8'h00;
  assign fcs      = ~crc;

  always_ff @(posedge eth_refclk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt + 8'd1;
    txen_d     = 1'b0;
    txd_d      = 2'b00;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    latch      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        crc_init = 1'b1;
        if (axiiv && axiir) begin
          next_state = PREAMBLE;
          latch      = 1'b1;
        end
      end
      PREAMBLE: begin
        txen_d   = 1'b1;
        txd_d    = pre_byte[{cnt[1:0], 1'b0} +: 2];
        crc_init = 1'b1;
        if (cnt == 8'(PREAMBLE_CYCLES - 1)) begin
          next_state = HEADER;
          cnt_next   = '0;
        end
      end
      HEADER: begin
        txen_d = 1'b1;
        txd_d  = hdr_byte[{cnt[1:0], 1'b0} +: 2];
        crc_en = 1'b1;
        if (cnt == 8'(HEADER_CYCLES - 1)) begin
          next_state = PAYLOAD;
          cnt_next   = '0;
        end
      end
      PAYLOAD: begin
        txen_d = 1'b1;
        txd_d  = pay_byte[{cnt[1:0], 1'b0} +: 2];
        crc_en = 1'b1;
        if (cnt == 8'(PAYLOAD_CYCLES - 1)) begin
          next_state = FCS;
          cnt_next   = '0;
        end
      end
      FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs[{cnt[3:0], 1'b0} +: 2];
        if (cnt == 8'(FCS_CYCLES - 1)) begin
          next_state = IFG;
          cnt_next   = '0;
        end
      end
      IFG: begin
        // Outputs lag the state by one register, so one cycle of the gap is spent in IDLE.
        if (cnt == 8'(IFG_CYCLES - 2)) begin
          next_state = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge eth_refclk or negedge rstn) begin
    if (!rstn) begin
      word <= '0;
    end else if (latch) begin
      word <= axiid;
    end
  end

  // The CRC advances on the same edge that registers its dibit onto eth_txd.
  crc32_dibit u_crc (
    .clk  (eth_refclk),
    .rstn (rstn),
    .init (crc_init),
    .en   (crc_en),
    .d    (txd_d),
    .crc  (crc)
  );

  always_ff @(posedge eth_refclk or negedge rstn) begin
    if (!rstn) begin
      eth_txen <= 1'b0;
      eth_txd  <= 2'b00;
      axiir    <= 1'b0;
    end else begin
      eth_txen <= txen_d;
      eth_txd  <= txd_d;
      axiir    <= (next_state == IDLE);
    end
  end

endmodule

// File: tb/tb_transmit.sv
// tb/tb_transmit.sv - bench for the RMII transmit framer
module tb_transmit;

  localparam logic [47:0] DEST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC   = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        axiiv = 1'b0;
  logic [31:0] axiid = '0;
  logic        axiir;
  logic        eth_txen;
  logic [1:0]  eth_txd;

  transmit #(.DEST_MAC(DEST), .SRC_MAC(SRC), .ETHERTYPE(ETYPE)) dut (
    .eth_refclk (clk),
    .rstn       (rstn),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiir      (axiir),
    .eth_txen   (eth_txen),
    .eth_txd    (eth_txd)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [1:0] cap[$];
  int foff[$], flen[$], fstart[$], fgap[$];
  bit in_frame = 0;
  int low_run = 0;
  int busy_ready_err = 0;
  int idle_err = 0;
  logic [7:0] exp_bytes[$];

  always @(posedge clk) cyc++;

  // Line monitor: splits the TX_EN stream into frames.
  always @(negedge clk) begin
    if (eth_txen === 1'b1) begin
      if (!in_frame) begin
        in_frame = 1;
        foff.push_back(cap.size());
        fstart.push_back(cyc);
        fgap.push_back(low_run);
        flen.push_back(0);
      end
      cap.push_back(eth_txd);
      flen[flen.size()-1] = flen[flen.size()-1] + 1;
      if (axiir !== 1'b0) busy_ready_err++;
      low_run = 0;
    end else begin
      in_frame = 0;
      low_run++;
      if (eth_txd !== 2'b00) idle_err++;
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = ((r[0] ^ b[i]) != 1'b0) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_expected(input logic [31:0] w);
    logic [31:0] c;
    exp_bytes.delete();
    repeat (7) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_bytes.push_back(DEST[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_bytes.push_back(SRC[8*i +: 8]);
    for (int i = 1; i >= 0; i--) exp_bytes.push_back(ETYPE[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
    repeat (42) exp_bytes.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++) c = crc_byte(c, exp_bytes[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp_bytes.push_back(c[8*i +: 8]);
  endtask

  function automatic logic [7:0] got_byte(input int fi, input int bi);
    int o;
    o = foff[fi] + 4 * bi;
    return {cap[o+3], cap[o+2], cap[o+1], cap[o]};
  endfunction

  task automatic check_frame(input int fi, input logic [31:0] w, input string tag);
    int bad, first;
    logic [31:0] c;
    build_expected(w);
    n_tests++;
    if (fi >= flen.size()) begin
      n_fail++;
      $display("FAIL %s_present: got %0d frames, expected at least %0d", tag, flen.size(), fi + 1);
      return;
    end
    if (flen[fi] !== 288) begin
      n_fail++;
      $display("FAIL %s_len: got %0d txen cycles, expected 288", tag, flen[fi]);
    end
    if (flen[fi] >= 288) begin
      n_tests++;
      bad = 0;
      first = -1;
      for (int i = 0; i < 72; i++)
        if (got_byte(fi, i) !== exp_bytes[i]) begin
          bad++;
          if (first < 0) first = i;
        end
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s_bytes: %0d wrong bytes, first at %0d got %02h expected %02h",
                 tag, bad, first, got_byte(fi, first), exp_bytes[first]);
      end
      n_tests++;
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 72; i++) c = crc_byte(c, got_byte(fi, i));
      if (c !== RESIDUE) begin
        n_fail++;
        $display("FAIL %s_residue: got %08h expected %08h", tag, c, RESIDUE);
      end
    end
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t;
    t = 0;
    while ((flen.size() < n || in_frame) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d frames, expected %0d", tag, flen.size(), n);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (axiir !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_ready_timeout: axiir got %b expected 1", tag, axiir);
    end
    axiiv = 1'b1;
    axiid = w;
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    axiid = $urandom;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 3;
    if (eth_txen !== 1'b0) begin n_fail++; $display("FAIL rst_txen: got %b expected 0", eth_txen); end
    if (eth_txd !== 2'b00) begin n_fail++; $display("FAIL rst_txd: got %b expected 00", eth_txd); end
    if (axiir !== 1'b0) begin n_fail++; $display("FAIL rst_axiir: got %b expected 0", axiir); end
    rstn = 1'b1;
    #1;
    n_tests++;
    if (axiir !== 1'b0) begin n_fail++; $display("FAIL rel_axiir_pre: got %b expected 0", axiir); end
    @(posedge clk);
    #1;
    n_tests++;
    if (axiir !== 1'b1) begin n_fail++; $display("FAIL rel_axiir_post: got %b expected 1", axiir); end
  endtask

  task automatic test_single_frame();
    int n0;
    n0 = flen.size();
    send_word(32'hDEAD_BEEF, "single");
    wait_frames(n0 + 1, "single");
    check_frame(n0, 32'hDEAD_BEEF, "single");
  endtask

  task automatic test_fcs_zero();
    int n0;
    logic [31:0] got, exp;
    n0 = flen.size();
    send_word(32'h0000_0000, "fcs0");
    wait_frames(n0 + 1, "fcs0");
    check_frame(n0, 32'h0000_0000, "fcs0");
    build_expected(32'h0000_0000);
    exp = {exp_bytes[71], exp_bytes[70], exp_bytes[69], exp_bytes[68]};
    got = '0;
    if (n0 < flen.size() && flen[n0] >= 288)
      got = {got_byte(n0, 71), got_byte(n0, 70), got_byte(n0, 69), got_byte(n0, 68)};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL fcs0_value: got %08h expected %08h", got, exp); end
  endtask

  task automatic test_back_to_back();
    int base, t, err0;
    err0 = busy_ready_err;
    base = flen.size();
    axiid = 32'd1;
    axiiv = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (axiir !== 1'b1 && t < 1000);
      if (t >= 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL b2b_ready_timeout: word %0d axiir got %b expected 1", i, axiir);
        break;
      end
      @(posedge clk);
      #1;
      if (i < 3) axiid = 32'(i + 1);
      else begin
        axiiv = 1'b0;
        axiid = $urandom;
      end
    end
    axiiv = 1'b0;
    wait_frames(base + 3, "b2b");
    for (int i = 0; i < 3; i++) check_frame(base + i, 32'(i + 1), $sformatf("b2b%0d", i));
    for (int i = 1; i < 3; i++) begin
      n_tests += 2;
      if (flen.size() < base + 3) begin
        n_fail += 2;
        $display("FAIL b2b_spacing%0d: got %0d frames, expected %0d", i, flen.size(), base + 3);
      end else begin
        if (fstart[base+i] - fstart[base+i-1] !== 336) begin
          n_fail++;
          $display("FAIL b2b_period%0d: got %0d cycles expected 336", i, fstart[base+i] - fstart[base+i-1]);
        end
        if (fgap[base+i] !== 48) begin
          n_fail++;
          $display("FAIL b2b_gap%0d: got %0d low cycles expected 48", i, fgap[base+i]);
        end
      end
    end
    n_tests++;
    if (busy_ready_err !== err0) begin
      n_fail++;
      $display("FAIL b2b_ready_in_frame: got %0d cycles with axiir high expected 0", busy_ready_err - err0);
    end
  endtask

  task automatic test_busy_drop();
    int n0;
    logic [31:0] w;
    w = $urandom;
    n0 = flen.size();
    send_word(w, "drop");
    wait_frames(n0 + 1, "drop");
    check_frame(n0, w, "drop");
    repeat (5) @(negedge clk);
    axiiv = 1'b1;
    axiid = 32'h1234_5678;
    n_tests++;
    if (axiir !== 1'b0) begin n_fail++; $display("FAIL drop_ifg_ready: got %b expected 0", axiir); end
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    repeat (700) @(negedge clk);
    n_tests++;
    if (flen.size() !== n0 + 1) begin
      n_fail++;
      $display("FAIL drop_extra_frame: got %0d frames expected %0d", flen.size(), n0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n0, n1, t;
    logic [31:0] w;
    w = $urandom;
    n0 = flen.size();
    send_word(w, "midrst");
    t = 0;
    while (eth_txen !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (99) @(negedge clk);
    #3;
    rstn = 1'b0;
    #1;
    n_tests += 2;
    if (eth_txen !== 1'b0) begin n_fail++; $display("FAIL midrst_txen: got %b expected 0", eth_txen); end
    if (eth_txd !== 2'b00) begin n_fail++; $display("FAIL midrst_txd: got %b expected 00", eth_txd); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (flen.size() !== n0 + 1 || flen[flen.size()-1] >= 288) begin
      n_fail++;
      $display("FAIL midrst_trunc: got %0d frames last len %0d expected %0d frames shorter than 288",
               flen.size(), (flen.size() > 0) ? flen[flen.size()-1] : 0, n0 + 1);
    end
    w = $urandom;
    n1 = flen.size();
    send_word(w, "after_rst");
    wait_frames(n1 + 1, "after_rst");
    check_frame(n1, w, "after_rst");
  endtask

  task automatic test_random_frames();
    int n0;
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      n0 = flen.size();
      send_word(w, "rand");
      wait_frames(n0 + 1, "rand");
      check_frame(n0, w, $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_fcs_zero();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid();
    test_random_frames();
    n_tests += 2;
    if (idle_err !== 0) begin n_fail++; $display("FAIL idle_txd: got %0d nonzero idle dibits expected 0", idle_err); end
    if (busy_ready_err !== 0) begin n_fail++; $display("FAIL ready_in_frame: got %0d cycles expected 0", busy_ready_err); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
